// File: rtl/tx_gearbox_sched.sv
// tx_gearbox_sched: slot scheduler for a 64b/66b TX gearbox.
// Paces XGMII words into RUN slots and inserts SLIP cycles each period.
//
// Ports:
//   i_clk, i_reset    single clock, synchronous active-high reset
//   i_mac_valid       MAC presents a word this cycle
//   i_tx_trdy         downstream encoder/scrambler path ready
//   o_xgmii_valid     word forwarded this cycle (combinational in RUN)
//   o_mac_pause       MAC must hold its current word
//   o_seq             registered gearbox slot, 0..SEQ_WORDS+SLIP_CYCLES-1
//   o_word_odd        forwarded word is the upper half of a 64b block
//   o_slip            high during sync-header slip cycles
//   o_underrun        high on a ready RUN slot with no MAC word
// Optional (macro TX_GEARBOX_SCHED_STATS_EN):
//   o_underrun_cnt    16b saturating count of underrun slots
//   o_period_cnt      32b wrapping count of completed periods
//
// SEQ_WORDS must be even so slip entry always lands on a block boundary.
module tx_gearbox_sched #(
    parameter int SEQ_WORDS   = 64,
    parameter int SLIP_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mac_valid,
    input  logic        i_tx_trdy,
    output logic        o_xgmii_valid,
    output logic        o_mac_pause,
    output logic [6:0]  o_seq,
    output logic        o_word_odd,
    output logic        o_slip,
    output logic        o_underrun
`ifdef TX_GEARBOX_SCHED_STATS_EN
    ,
    output logic [15:0] o_underrun_cnt,
    output logic [31:0] o_period_cnt
`endif
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_SLIP = 2'd2
    } state_e;

    localparam logic [6:0] RUN_LAST  = 7'(SEQ_WORDS - 1);
    localparam logic [6:0] SLIP_LAST = 7'(SEQ_WORDS + SLIP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [6:0] seq_q, seq_d;
    logic       wrap;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_INIT;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
        end
    end

    // Next state: nothing moves while downstream is stalled, so a stall
    // on the last RUN/SLIP slot simply defers the transition.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        if (i_tx_trdy) begin
            unique case (state_q)
                S_INIT: begin
                    state_d = S_RUN;
                    seq_d   = '0;
                end
                S_RUN: begin
                    seq_d = seq_q + 7'd1;
                    if (seq_q == RUN_LAST) state_d = S_SLIP;
                end
                S_SLIP: begin
                    if (seq_q == SLIP_LAST) begin
                        seq_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        seq_d = seq_q + 7'd1;
                    end
                end
                default: begin
                    state_d = S_INIT;
                    seq_d   = '0;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        o_xgmii_valid = 1'b0;
        o_mac_pause   = 1'b1;
        o_word_odd    = 1'b0;
        o_slip        = 1'b0;
        o_underrun    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                o_xgmii_valid = i_mac_valid & i_tx_trdy;
                o_mac_pause   = ~i_tx_trdy;
                o_word_odd    = seq_q[0];
                o_underrun    = i_tx_trdy & ~i_mac_valid;
            end
            S_SLIP: o_slip = 1'b1;
            default: ;
        endcase
    end

    assign o_seq = seq_q;
    assign wrap  = (state_q == S_SLIP) && i_tx_trdy && (seq_q == SLIP_LAST);

`ifdef TX_GEARBOX_SCHED_STATS_EN
    logic [15:0] ucnt_q;
    logic [31:0] pcnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ucnt_q <= '0;
            pcnt_q <= '0;
        end else begin
            if (o_underrun && (ucnt_q != 16'hFFFF)) ucnt_q <= ucnt_q + 16'd1;
            if (wrap) pcnt_q <= pcnt_q + 32'd1;
        end
    end

    assign o_underrun_cnt = ucnt_q;
    assign o_period_cnt   = pcnt_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
`endif

endmodule

// File: tb/tb_tx_gearbox_sched.sv
// Bench for tx_gearbox_sched: slot-position model plus directed literals.
module tb_tx_gearbox_sched;

    localparam int NW  = 64;
    localparam int NS  = 2;
    localparam int PER = NW + NS;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_mac_valid = 1'b0;
    logic       i_tx_trdy = 1'b0;
    logic       o_xgmii_valid, o_mac_pause, o_word_odd, o_slip, o_underrun;
    logic [6:0] o_seq;
`ifdef TX_GEARBOX_SCHED_STATS_EN
    logic [15:0] o_underrun_cnt;
    logic [31:0] o_period_cnt;
`endif

    tx_gearbox_sched #(.SEQ_WORDS(NW), .SLIP_CYCLES(NS)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_mac_valid  (i_mac_valid),
        .i_tx_trdy    (i_tx_trdy),
        .o_xgmii_valid(o_xgmii_valid),
        .o_mac_pause  (o_mac_pause),
        .o_seq        (o_seq),
        .o_word_odd   (o_word_odd),
        .o_slip       (o_slip),
        .o_underrun   (o_underrun)
`ifdef TX_GEARBOX_SCHED_STATS_EN
        ,
        .o_underrun_cnt(o_underrun_cnt),
        .o_period_cnt (o_period_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model: started = left INIT; pos = slot within the period.
    bit started = 0;
    int pos = 0;
    int m_under = 0;
    longint m_per = 0;
    bit chk_en = 0;

    logic       s_valid, s_pause, s_odd, s_slip, s_under;
    logic [6:0] s_seq;

    function automatic void chk(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    function automatic void model_step(logic r, logic t, logic m);
        bit run;
        run = started && (pos < NW);
        if (r) begin
            started = 0;
            pos = 0;
            m_under = 0;
            m_per = 0;
        end else if (t) begin
            if (run && !m && m_under < 65535) m_under++;
            if (!started) begin
                started = 1;
            end else begin
                if (pos == PER - 1) m_per++;
                pos = (pos + 1) % PER;
            end
        end
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit run;
            run = started && (pos < NW);
            chk("seq", o_seq, pos);
            chk("valid", o_xgmii_valid, run && i_tx_trdy && i_mac_valid);
            chk("pause", o_mac_pause, !(run && i_tx_trdy));
            chk("slip", o_slip, started && pos >= NW);
            chk("odd", o_word_odd, run ? pos % 2 : 0);
            chk("underrun", o_underrun, run && i_tx_trdy && !i_mac_valid);
`ifdef TX_GEARBOX_SCHED_STATS_EN
            chk("ucnt", o_underrun_cnt, m_under);
            chk("pcnt", o_period_cnt, m_per & 64'hFFFF_FFFF);
`endif
        end
    end

    task automatic cyc(input logic r, input logic t, input logic m);
        i_reset = r;
        i_tx_trdy = t;
        i_mac_valid = m;
        @(negedge clk);
        s_valid = o_xgmii_valid;
        s_pause = o_mac_pause;
        s_odd   = o_word_odd;
        s_slip  = o_slip;
        s_under = o_underrun;
        s_seq   = o_seq;
        @(posedge clk);
        model_step(r, t, m);
        #1;
    endtask

    initial begin
        int nv, nsl, first_slip;
        cyc(1, 1, 1);
        chk_en = 1;
        cyc(1, 1, 1);
        chk("rst_seq", s_seq, 0);
        chk("rst_pause", s_pause, 1);
        chk("rst_valid", s_valid, 0);

        // Continuous traffic: INIT cycle then two full periods.
        nv = 0; nsl = 0; first_slip = -1;
        for (int i = 0; i < 1 + 2 * PER; i++) begin
            cyc(0, 1, 1);
            nv += s_valid;
            nsl += s_slip;
            if (s_slip && first_slip < 0) first_slip = s_seq;
        end
        chk("valid_cnt", nv, 128);
        chk("slip_cnt", nsl, 4);
        chk("slip_first_seq", first_slip, 64);

        // Stall at seq 10.
        for (int i = 0; i < 10; i++) cyc(0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1);
            chk("stall_seq", s_seq, 10);
            chk("stall_pause", s_pause, 1);
            chk("stall_valid", s_valid, 0);
        end
        cyc(0, 1, 1);
        chk("resume10", s_seq, 10);
        cyc(0, 1, 1);
        chk("resume11", s_seq, 11);

        // Stall on the last RUN slot.
        for (int i = 0; i < 51; i++) cyc(0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1);
            chk("stall63", s_seq, 63);
            chk("stall63_slip", s_slip, 0);
        end
        cyc(0, 1, 1);
        chk("last63", s_seq, 63);
        cyc(0, 1, 1);
        chk("slip64", s_seq, 64);
        chk("slip64_flag", s_slip, 1);
        chk("slip64_odd", s_odd, 0);

        // Reset on seq 65.
        cyc(1, 1, 1);
        chk("pre_rst65", s_seq, 65);
        cyc(0, 0, 1);
        chk("init_seq", s_seq, 0);
        chk("init_pause", s_pause, 1);
        cyc(0, 1, 1);
        chk("init_valid", s_valid, 0);
        cyc(0, 1, 1);
        chk("run0_seq", s_seq, 0);
        chk("run0_valid", s_valid, 1);

        // Underrun at seq 7.
        for (int i = 0; i < 6; i++) cyc(0, 1, 1);
        cyc(0, 1, 0);
        chk("ur_seq", s_seq, 7);
        chk("ur_pulse", s_under, 1);
        chk("ur_odd", s_odd, 1);
        cyc(0, 1, 1);
        chk("ur_next", s_seq, 8);
        chk("ur_clear", s_under, 0);

`ifdef TX_GEARBOX_SCHED_STATS_EN
        cyc(1, 1, 1);
        cyc(0, 1, 1);
        for (int i = 0; i < 3 * PER; i++)
            cyc(0, 1, (i == 3 || i == 100) ? 1'b0 : 1'b1);
        cyc(0, 0, 1);
        chk("stat_per", o_period_cnt, 3);
        chk("stat_ur", o_underrun_cnt, 2);
`endif

        // Randomised traffic, stalls and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 9) < 8,
                $urandom_range(0, 9) < 9);
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tx_gearbox_sched.md
TX_GEARBOX_SCHED -- requirements
Module: tx_gearbox_sched

Interface
REQ-001 SHALL have parameter SEQ_WORDS, default 64, meaning 32-bit words accepted per gearbox period (32 x 66b blocks).
REQ-002 SHALL have parameter SLIP_CYCLES, default 2, meaning idle cycles per period that absorb the 32 x 2-bit sync headers.
REQ-003 SHALL have port i_clk  input  1  single clock for all logic.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_mac_valid  input  1  MAC presents an XGMII word this cycle.
REQ-006 SHALL have port i_tx_trdy  input  1  downstream encoder/scrambler path ready.
REQ-007 SHALL have port o_xgmii_valid  output  1  word forwarded to encoder this cycle.
REQ-008 SHALL have port o_mac_pause  output  1  MAC must hold its current word.
REQ-009 SHALL have port o_seq  output  7  gearbox sequence position, 0..SEQ_WORDS+SLIP_CYCLES-1.
REQ-010 SHALL have port o_word_odd  output  1  forwarded word is the upper 32 bits of a 64b block.
REQ-011 SHALL have port o_slip  output  1  high during slip cycles.
REQ-012 SHALL have port o_underrun  output  1  one-cycle pulse on a missing word in a RUN slot.

Function
REQ-013 SHALL implement FSM states INIT, RUN, SLIP.
REQ-014 INIT: o_mac_pause=1, o_xgmii_valid=0; SHALL go to RUN with seq=0 on the first cycle i_tx_trdy=1.
REQ-015 RUN: when i_tx_trdy=1, seq SHALL increment by 1 per cycle; at seq=SEQ_WORDS-1 SHALL go to SLIP with seq=SEQ_WORDS.
REQ-016 SLIP: o_slip=1, o_mac_pause=1, o_xgmii_valid=0; seq SHALL increment each trdy cycle; at seq=SEQ_WORDS+SLIP_CYCLES-1 SHALL wrap to 0 and go to RUN.
REQ-017 Slip entry SHALL fall only on a block boundary (o_word_odd=0 at seq=SEQ_WORDS); SEQ_WORDS SHALL be even.
REQ-018 In RUN, o_xgmii_valid SHALL equal i_mac_valid & i_tx_trdy, combinationally, with zero latency.
REQ-019 In RUN, o_mac_pause SHALL equal ~i_tx_trdy.
REQ-020 While i_tx_trdy=0 in any state: seq, state and o_word_odd SHALL freeze; o_xgmii_valid=0.
REQ-021 o_word_odd SHALL equal seq[0] in RUN and 0 in SLIP and INIT.
REQ-022 A RUN cycle with i_tx_trdy=1 and i_mac_valid=0 SHALL pulse o_underrun for one cycle; seq SHALL still advance.
REQ-023 A trdy drop on the last RUN or last SLIP cycle SHALL defer the transition until trdy returns; no slot SHALL be skipped or duplicated.
REQ-024 o_seq SHALL be registered; o_xgmii_valid, o_mac_pause and o_slip SHALL be decoded from registered state plus i_mac_valid/i_tx_trdy only.

Reset
REQ-025 On i_reset=1 at a clock edge, state=INIT, seq=0, o_underrun=0, o_word_odd=0, o_slip=0, o_xgmii_valid=0, o_mac_pause=1.
REQ-026 Reset mid-RUN or mid-SLIP SHALL abandon the period; after release the block SHALL restart from INIT.
REQ-027 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-028 With macro TX_GEARBOX_SCHED_STATS_EN defined, the block SHALL add outputs o_underrun_cnt (16b, saturating) and o_period_cnt (32b, wrapping), incremented per o_underrun pulse and per SLIP->RUN wrap, both cleared by reset.
REQ-029 With TX_GEARBOX_SCHED_STATS_EN undefined, these ports and counters SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-030 Reset release, i_tx_trdy=1, i_mac_valid=1 held -> o_xgmii_valid high for 64 cycles, low for 2 (o_slip=1, o_seq=64,65), repeating with period 66.
REQ-031 i_tx_trdy=0 for 5 cycles at seq=10 -> o_seq holds 10, o_xgmii_valid=0, o_mac_pause=1; resumes at 11 with no lost slot.
REQ-032 i_tx_trdy=0 at seq=63 for 3 cycles -> SLIP entered only after trdy returns; o_seq goes 63,63,63,63,64.
REQ-033 i_mac_valid=0 at seq=7 -> single o_underrun pulse, o_word_odd=1, seq advances to 8.
REQ-034 i_reset=1 at seq=65 -> next cycle state INIT, o_seq=0, o_mac_pause=1; first trdy cycle starts RUN at seq 0.
REQ-035 With TX_GEARBOX_SCHED_STATS_EN: 3 full periods plus 2 underruns -> o_period_cnt=3, o_underrun_cnt=2.
